// File: rtl/word_packer.sv
// word_packer: packs NUM_WORDS words of WORD_W bits into one block behind
// valid/ready handshakes on both sides. The first word goes to the MS or LS
// slot depending on MSW_FIRST. in_last closes a frame early.
module word_packer #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 4,
  parameter int MSW_FIRST = 1
) (
  input  logic                               CLK,
  input  logic                               RESET_N,
  input  logic                               clear,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WORD_W-1:0]                  in_word,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WORD_W*NUM_WORDS-1:0]        out_data,
  output logic [$clog2(NUM_WORDS+1)-1:0]     out_words
);

  localparam int CW = $clog2(NUM_WORDS);
  localparam int WW = $clog2(NUM_WORDS+1);

  typedef enum logic {FILL, HOLD} state_e;

  state_e                         state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic                           in_ready_q, in_ready_d;
  logic                           out_valid_q, out_valid_d;
  logic [WORD_W*NUM_WORDS-1:0]    data_q, data_d;
  logic [WW-1:0]                  words_q, words_d;
  logic                           accept;
  int unsigned                    slot;

  assign accept    = in_valid && in_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign out_words = words_q;

  // State and datapath registers; reset clears everything, in_ready included.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      words_q     <= words_d;
    end
  end

  // Next-state logic; the handshake flags are computed one cycle ahead so
  // that in_ready and out_valid leave the block straight from flops.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    words_d     = words_q;
    slot        = (MSW_FIRST != 0) ? (NUM_WORDS - 1 - int'(cnt_q)) : int'(cnt_q);

    if (clear) begin
      state_d     = FILL;
      cnt_d       = '0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
      data_d      = '0;
      words_d     = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          in_ready_d = 1'b1;
          if (accept) begin
            data_d[slot*WORD_W +: WORD_W] = in_word;
            if (in_last || cnt_q == CW'(NUM_WORDS - 1)) begin
              state_d     = HOLD;
              words_d     = WW'(cnt_q) + WW'(1);
              in_ready_d  = 1'b0;
              out_valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d     = FILL;
            cnt_d       = '0;
            data_d      = '0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_word_packer.sv
// Directed bench for word_packer: default, LS-first and 8-bit/3-word builds.
module tb_word_packer;

  logic CLK = 1'b0;
  logic rst_n;
  always #5 CLK = ~CLK;

  // shared stimulus for the two 32x4 builds
  logic         clr, iv, il, ordy;
  logic [31:0]  iw;
  logic         ir0, ov0, ir1, ov1;
  logic [127:0] od0, od1;
  logic [2:0]   ow0, ow1;

  // 8x3 build
  logic         clr2, iv2, il2, ordy2;
  logic [7:0]   iw2;
  logic         ir2, ov2;
  logic [23:0]  od2;
  logic [1:0]   ow2;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_data_q[$];
  logic [2:0]   exp_words_q[$];
  logic [127:0] held;

  word_packer #(.WORD_W(32), .NUM_WORDS(4), .MSW_FIRST(1)) u0 (
    .CLK(CLK), .RESET_N(rst_n), .clear(clr), .in_valid(iv), .in_ready(ir0),
    .in_word(iw), .in_last(il), .out_valid(ov0), .out_ready(ordy),
    .out_data(od0), .out_words(ow0));

  word_packer #(.WORD_W(32), .NUM_WORDS(4), .MSW_FIRST(0)) u1 (
    .CLK(CLK), .RESET_N(rst_n), .clear(clr), .in_valid(iv), .in_ready(ir1),
    .in_word(iw), .in_last(il), .out_valid(ov1), .out_ready(ordy),
    .out_data(od1), .out_words(ow1));

  word_packer #(.WORD_W(8), .NUM_WORDS(3), .MSW_FIRST(1)) u2 (
    .CLK(CLK), .RESET_N(rst_n), .clear(clr2), .in_valid(iv2), .in_ready(ir2),
    .in_word(iw2), .in_last(il2), .out_valid(ov2), .out_ready(ordy2),
    .out_data(od2), .out_words(ow2));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic last);
    iv = 1'b1; iw = w; il = last;
    tick();
    iv = 1'b0; il = 1'b0;
  endtask

  task automatic push(input logic [127:0] d, input logic [2:0] n);
    exp_data_q.push_back(d);
    exp_words_q.push_back(n);
  endtask

  // waits (bounded) for u0 out_valid, then pops and compares the scoreboard
  task automatic expect_block(input string tag);
    logic [127:0] d;
    logic [2:0]   n;
    for (int i = 0; i < 8; i++) begin
      if (ov0) break;
      tick();
    end
    chk({tag, "_ov"}, 128'(ov0), 128'(1));
    if (exp_data_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 128'(0), 128'(1));
    end else begin
      d = exp_data_q.pop_front();
      n = exp_words_q.pop_front();
      chk({tag, "_data"}, od0, d);
      chk({tag, "_words"}, 128'(ow0), 128'(n));
      chk({tag, "_ir_low"}, 128'(ir0), 128'(0));
    end
  endtask

  task automatic send2(input logic [7:0] w, input logic last);
    iv2 = 1'b1; iw2 = w; il2 = last;
    tick();
    iv2 = 1'b0; il2 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0; iv = 1'b0; il = 1'b0; iw = '0; ordy = 1'b1;
    clr2 = 1'b0; iv2 = 1'b0; il2 = 1'b0; iw2 = '0; ordy2 = 1'b1;

    // reset values (one clock edge already seen while in reset)
    #12;
    chk("rst_ir", 128'(ir0), 128'(0));
    chk("rst_ov", 128'(ov0), 128'(0));
    chk("rst_data", od0, 128'(0));
    chk("rst_words", 128'(ow0), 128'(0));
    rst_n = 1'b1;
    tick();
    chk("post_rst_ir", 128'(ir0), 128'(1));
    chk("post_rst_ir2", 128'(ir2), 128'(1));

    // full frame, both word orders
    send(32'h00112233, 1'b0);
    send(32'h44556677, 1'b0);
    send(32'h8899AABB, 1'b0);
    push(128'h00112233_44556677_8899AABB_CCDDEEFF, 3'd4);
    send(32'hCCDDEEFF, 1'b0);
    expect_block("full");
    chk("lsw_data", od1, 128'hCCDDEEFF_8899AABB_44556677_00112233);
    chk("lsw_words", 128'(ow1), 128'(4));
    tick();
    chk("handoff_ir", 128'(ir0), 128'(1));
    chk("handoff_ov", 128'(ov0), 128'(0));

    // early termination, then in_last on first word
    send(32'hDEADBEEF, 1'b0);
    push(128'hDEADBEEF_01234567_00000000_00000000, 3'd2);
    send(32'h01234567, 1'b1);
    expect_block("early");
    chk("early_lsw", od1, 128'h00000000_00000000_01234567_DEADBEEF);
    tick();
    push(128'h55555555_00000000_00000000_00000000, 3'd1);
    send(32'h55555555, 1'b1);
    expect_block("first_last");
    tick();

    // backpressure; in_last on the final slot gives a normal full block
    ordy = 1'b0;
    send(32'h01010101, 1'b0);
    send(32'h02020202, 1'b0);
    send(32'h03030303, 1'b0);
    push(128'h01010101_02020202_03030303_04040404, 3'd4);
    send(32'h04040404, 1'b1);
    expect_block("bp");
    held = od0;
    iv = 1'b1; iw = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stable", od0, 128'h01010101_02020202_03030303_04040404);
      chk("bp_ir", 128'(ir0), 128'(0));
      chk("bp_ov", 128'(ov0), 128'(1));
    end
    chk("bp_held", od0, held);
    iv = 1'b0;
    ordy = 1'b1;
    tick();
    push(128'h77777777_00000000_00000000_00000000, 3'd1);
    send(32'h77777777, 1'b1);
    expect_block("bp_next");
    tick();

    // abort a partial frame; word presented with clear is dropped
    send(32'h11111111, 1'b0);
    send(32'h22222222, 1'b0);
    clr = 1'b1; iv = 1'b1; iw = 32'hEEEEEEEE;
    tick();
    clr = 1'b0; iv = 1'b0;
    chk("clr_ir", 128'(ir0), 128'(1));
    chk("clr_ov", 128'(ov0), 128'(0));
    chk("clr_data", od0, 128'(0));
    send(32'hA0A0A0A0, 1'b0);
    send(32'hB1B1B1B1, 1'b0);
    send(32'hC2C2C2C2, 1'b0);
    push(128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3, 3'd4);
    send(32'hD3D3D3D3, 1'b0);
    expect_block("abort");

    // clear while holding a block
    ordy = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_hold_ov", 128'(ov0), 128'(0));
    chk("clr_hold_data", od0, 128'(0));
    chk("clr_hold_words", 128'(ow0), 128'(0));
    chk("clr_hold_ir", 128'(ir0), 128'(1));

    // asynchronous reset while holding
    send(32'h10101010, 1'b0);
    send(32'h20202020, 1'b0);
    send(32'h30303030, 1'b0);
    push(128'h10101010_20202020_30303030_40404040, 3'd4);
    send(32'h40404040, 1'b0);
    expect_block("pre_rst");
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ov", 128'(ov0), 128'(0));
    chk("arst_data", od0, 128'(0));
    chk("arst_ir", 128'(ir0), 128'(0));
    chk("arst_words", 128'(ow0), 128'(0));
    #2 rst_n = 1'b1;
    tick();
    chk("arst_rel_ir", 128'(ir0), 128'(1));
    ordy = 1'b1;
    send(32'h0A0A0A0A, 1'b0);
    send(32'h0B0B0B0B, 1'b0);
    send(32'h0C0C0C0C, 1'b0);
    push(128'h0A0A0A0A_0B0B0B0B_0C0C0C0C_0D0D0D0D, 3'd4);
    send(32'h0D0D0D0D, 1'b0);
    expect_block("post_rst");
    tick();

    // 8-bit x 3 build
    send2(8'h11, 1'b0);
    send2(8'h22, 1'b0);
    send2(8'h33, 1'b0);
    chk("w8_ov", 128'(ov2), 128'(1));
    chk("w8_data", 128'(od2), 128'(24'h112233));
    chk("w8_words", 128'(ow2), 128'(3));
    tick();
    chk("w8_ir", 128'(ir2), 128'(1));
    send2(8'hAA, 1'b1);
    chk("w8_early_data", 128'(od2), 128'(24'hAA0000));
    chk("w8_early_words", 128'(ow2), 128'(1));

    chk("sb_empty", 128'(exp_data_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
